dmem_access_ctrl: RTL and testbench
===================================

// Module: dmem_access_ctrl
// PURPOSE
//  Single-outstanding data-memory access controller; sits directly downstream of the load/store buffer.
//  Captures one load/store request, holds it stable on the L1 D-cache port until mem_resp, then returns
//  read data and the ROB tag to the buffer. Also absorbs flushes: a cache access already launched always
//  completes, but its result is discarded.
// PARAMETERS
//  DATA_W  16  data/address width (lc3b_word)
//  TAG_W   3   ROB tag width carried with each request
// PORTS
//  clk              in   1       clock, all state on rising edge
//  rst_n            in   1       asynchronous active-low reset
//  flush            in   1       pipeline flush (mispredict); kills pending request/response
//  req_valid        in   1       buffer presents a request
//  req_ready        out  1       controller accepts request this cycle
//  req_write        in   1       1=store, 0=load
//  req_byte         in   1       1=LDB/STB, 0=LDR/STR (ignored unless DMEM_BYTE_ACCESS_EN)
//  req_addr         in   DATA_W  effective address
//  req_wdata        in   DATA_W  store data
//  req_tag          in   TAG_W   ROB tag of requesting instruction
//  resp_valid       out  1       one-cycle completion pulse to buffer
//  resp_rdata       out  DATA_W  load data (0 for stores)
//  resp_tag         out  TAG_W   tag of completed access
//  mem_read         out  1       cache read strobe
//  mem_write        out  1       cache write strobe
//  mem_address      out  DATA_W  cache address
//  mem_wdata        out  DATA_W  cache write data
//  mem_byte_enable  out  2       cache lane enables
//  mem_resp         in   1       cache completion
//  mem_rdata        in   DATA_W  cache read data
//  busy             out  1       FSM not IDLE
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 except req_ready=1; request/response registers cleared.
//  FSM IDLE -> ACCESS -> IDLE, with ACCESS -> DRAIN -> IDLE on flush.
//  IDLE: req_ready = !flush. A handshake (req_valid&req_ready) registers write/byte/addr/wdata/tag -> ACCESS.
//    If flush is high in IDLE, nothing is accepted.
//  ACCESS: mem_read=!wr, mem_write=wr, and address/data are driven only from the registers; they stay stable
//    until mem_resp. When mem_resp=1 and flush=0: next cycle resp_valid=1 for exactly one cycle, with resp_tag.
//    For loads, resp_rdata = registered mem_rdata; for stores it is 0. -> IDLE.
//    When mem_resp=1 and flush=1 in the same cycle: no resp_valid. -> IDLE.
//    When flush=1 and mem_resp=0: -> DRAIN.
//  DRAIN: strobes are held unchanged until mem_resp, then -> IDLE. resp_valid is never raised.
//    A flush arriving while in DRAIN has no extra effect.
//  req_ready=0 in ACCESS/DRAIN. The earliest next request is accepted in the cycle resp_valid is high,
//    so minimum occupancy is 2 cycles per access (one-cycle cache response).
//  A flush in the cycle resp_valid is high does not retract that pulse; the buffer discards it.
//  Reset asserted mid-access drops everything immediately; the cache is reset by the same rst_n.
//  Strobes are never both high. Strobes are low in IDLE.
// CONFIGURATION
//  `DMEM_BYTE_ACCESS_EN defined:
//    - req_byte=1 load: mem_byte_enable=2'b11 and addr is unchanged; resp_rdata = zero-extended byte,
//      high byte if addr[0] else low.
//    - req_byte=1 store: mem_wdata = {wdata[7:0],wdata[7:0]}; byte_enable = addr[0] ? 2'b10 : 2'b01.
//    - Word accesses force mem_address[0]=0 and use byte_enable=2'b11.
//  Not defined: req_byte is ignored; every access is a word access with mem_address[0]=0 and byte_enable=2'b11.
// STRUCTURE
//  Add to lc3b_types:
//    - typedef enum logic [1:0] {DMEM_IDLE, DMEM_ACCESS, DMEM_DRAIN} dmem_state_t
//    - typedef struct packed {write, byte_op, addr, wdata, tag} dmem_req_t (shared with buffer)
//  One sub-module, dmem_lane_align: combinational byte steering of store data/enables and load extraction.
//  The FSM and registers stay in the top.
// TESTING
//  1 Word load: req addr=0x1004, tag=5; mem_resp after 3 cycles with rdata=0xBEEF
//    -> one resp_valid, rdata=0xBEEF, tag=5; mem_read high exactly 3 cycles.
//  2 Word store: addr=0x2001, wdata=0x1234 -> mem_address=0x2000, byte_enable=2'b11, mem_write held until resp;
//    resp_rdata=0.
//  3 Flush in ACCESS before resp -> DRAIN; strobes held; no resp_valid after mem_resp; req_ready returns.
//  4 Flush coincident with mem_resp -> no resp_valid; IDLE next cycle; a new request is accepted afterwards.
//  5 Back-to-back: req_valid held high with a 1-cycle cache -> acceptance every 2 cycles and tags returned in order.
//    Reset mid-ACCESS -> all outputs at reset values immediately.
//  6 DMEM_BYTE_ACCESS_EN:
//    - STB addr=0x3003, wdata=0x00AB -> mem_wdata=0xABAB, byte_enable=2'b10.
//    - LDB addr=0x3003, rdata=0xC17F -> resp_rdata=0x00C1.
//    - Macro off: the same LDB returns 0xC17F.

Source files
------------

// File: rtl/dmem_access_ctrl_pkg.sv
// Shared types for the data-memory access path: controller FSM states and the request record
// exchanged with the load/store buffer.
package dmem_access_ctrl_pkg;

  localparam int LC3B_WORD_W = 16;
  localparam int ROB_TAG_W   = 3;

  typedef logic [LC3B_WORD_W-1:0] lc3b_word;

  typedef enum logic [1:0] {
    DMEM_IDLE,
    DMEM_ACCESS,
    DMEM_DRAIN
  } dmem_state_t;

  typedef struct packed {
    logic                 write;
    logic                 byte_op;
    lc3b_word             addr;
    lc3b_word             wdata;
    logic [ROB_TAG_W-1:0] tag;
  } dmem_req_t;

  // Lane enable for a single-byte store: odd addresses hit the high lane.
  function automatic logic [1:0] byte_lane_mask(input logic addr_lsb);
    return addr_lsb ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_lane_align.sv
// Combinational byte steering between the request and the cache port.
// Byte operations exist only when DMEM_BYTE_ACCESS_EN is defined; otherwise every access is a word access.
module dmem_lane_align
  import dmem_access_ctrl_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              write,
  input  logic              byte_op,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        byte_en,
  output logic [DATA_W-1:0] load_data
);

`ifdef DMEM_BYTE_ACCESS_EN
  always_comb begin
    mem_addr  = {addr[DATA_W-1:1], 1'b0};
    mem_wdata = wdata;
    byte_en   = 2'b11;
    load_data = rdata;
    if (byte_op) begin
      // Byte accesses keep the full address; the lane is chosen by addr[0].
      mem_addr = addr;
      if (write) begin
        mem_wdata = {(DATA_W/8){wdata[7:0]}};
        byte_en   = byte_lane_mask(addr[0]);
      end else begin
        load_data = addr[0] ? {{(DATA_W-8){1'b0}}, rdata[15:8]}
                            : {{(DATA_W-8){1'b0}}, rdata[7:0]};
      end
    end
  end
`else
  logic unused_byte_path;
  assign unused_byte_path = ^{write, byte_op, addr[0]};

  assign mem_addr  = {addr[DATA_W-1:1], 1'b0};
  assign mem_wdata = wdata;
  assign byte_en   = 2'b11;
  assign load_data = rdata;
`endif

endmodule

// File: rtl/dmem_access_ctrl.sv
// Single-outstanding data-memory access controller between the load/store buffer and the L1 D-cache.
// Optional byte (LDB/STB) steering is enabled by defining DMEM_BYTE_ACCESS_EN.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [TAG_W-1:0]  resp_tag,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_byte_enable,
  input  logic              mem_resp,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready; resp_valid is a
  // one-cycle pulse the buffer must take unconditionally (there is no resp_ready).
  dmem_state_t state_q, state_d;

  logic              wr_q;
  logic              byte_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [TAG_W-1:0]  tag_q;

  logic              resp_valid_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic [TAG_W-1:0]  resp_tag_q;

  logic [DATA_W-1:0] al_addr, al_wdata, al_load;
  logic [1:0]        al_be;

  logic accept, complete;

  assign busy      = (state_q != DMEM_IDLE);
  assign req_ready = (state_q == DMEM_IDLE) && !flush;
  assign accept    = req_valid && req_ready;
  // A response launched before or during a flush is completed on the cache side but never reported.
  assign complete  = (state_q == DMEM_ACCESS) && mem_resp && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= DMEM_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DMEM_IDLE:   if (accept) state_d = DMEM_ACCESS;
      DMEM_ACCESS: begin
        if (mem_resp)   state_d = DMEM_IDLE;
        else if (flush) state_d = DMEM_DRAIN;
      end
      DMEM_DRAIN:  if (mem_resp) state_d = DMEM_IDLE;
      default:     state_d = DMEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= 1'b0;
      byte_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      tag_q   <= '0;
    end else if (accept) begin
      wr_q    <= req_write;
      byte_q  <= req_byte;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      tag_q   <= req_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_tag_q   <= '0;
    end else begin
      resp_valid_q <= complete;
      if (complete) begin
        resp_rdata_q <= wr_q ? '0 : al_load;
        resp_tag_q   <= tag_q;
      end
    end
  end

  dmem_lane_align #(.DATA_W(DATA_W)) u_lane_align (
    .write     (wr_q),
    .byte_op   (byte_q),
    .addr      (addr_q),
    .wdata     (wdata_q),
    .rdata     (mem_rdata),
    .mem_addr  (al_addr),
    .mem_wdata (al_wdata),
    .byte_en   (al_be),
    .load_data (al_load)
  );

  // Cache port is driven purely from the captured request, and is quiet whenever idle.
  assign mem_read        = busy && !wr_q;
  assign mem_write       = busy && wr_q;
  assign mem_address     = busy ? al_addr  : '0;
  assign mem_wdata       = busy ? al_wdata : '0;
  assign mem_byte_enable = busy ? al_be    : 2'b00;

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_tag   = resp_tag_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: word load/store, flush in ACCESS/DRAIN/with mem_resp,
// back-to-back requests, reset mid-access, and byte steering under DMEM_BYTE_ACCESS_EN.
module tb_dmem_access_ctrl;

  logic        clk, rst_n, flush;
  logic        req_valid, req_ready, req_write, req_byte;
  logic [15:0] req_addr, req_wdata;
  logic [2:0]  req_tag;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic [2:0]  resp_tag;
  logic        mem_read, mem_write;
  logic [15:0] mem_address, mem_wdata;
  logic [1:0]  mem_byte_enable;
  logic        mem_resp;
  logic [15:0] mem_rdata;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  logic [2:0] exp_q[$];

  dmem_access_ctrl #(.DATA_W(16), .TAG_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_byte(req_byte),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_tag(resp_tag),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata), .busy(busy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".mem_read"},  {31'd0, mem_read},  32'd0);
    chk({tag, ".mem_write"}, {31'd0, mem_write}, 32'd0);
    chk({tag, ".mem_addr"},  {16'd0, mem_address}, 32'd0);
    chk({tag, ".busy"},      {31'd0, busy},      32'd0);
    chk({tag, ".req_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  // Drives one complete access from the IDLE state; cache answers on the lat-th ACCESS cycle.
  task automatic do_access(input string tag, input logic wr, input logic bt,
                           input logic [15:0] addr, input logic [15:0] wdata, input logic [2:0] rtag,
                           input int lat, input logic [15:0] rdata,
                           input logic [15:0] exp_addr, input logic [15:0] exp_wdata,
                           input logic [1:0] exp_be, input logic [15:0] exp_rdata);
    int strobe_cycles;
    strobe_cycles = 0;
    req_valid = 1'b1; req_write = wr; req_byte = bt;
    req_addr = addr; req_wdata = wdata; req_tag = rtag;
    #1;
    chk({tag, ".accept_ready"}, {31'd0, req_ready}, 32'd1);
    tick;
    req_valid = 1'b0; req_addr = 16'hFFFF; req_wdata = 16'hFFFF;
    for (int i = 0; i < lat; i++) begin
      #1;
      chk({tag, ".addr"}, {16'd0, mem_address}, {16'd0, exp_addr});
      chk({tag, ".be"},   {30'd0, mem_byte_enable}, {30'd0, exp_be});
      chk({tag, ".rd"},   {31'd0, mem_read},  {31'd0, !wr});
      chk({tag, ".wr"},   {31'd0, mem_write}, {31'd0, wr});
      if (wr) chk({tag, ".wdata"}, {16'd0, mem_wdata}, {16'd0, exp_wdata});
      chk({tag, ".busy_ready"}, {30'd0, busy, req_ready}, 32'd2);
      if (mem_read || mem_write) strobe_cycles++;
      if (i == lat - 1) begin
        mem_resp = 1'b1;
        mem_rdata = rdata;
      end
      tick;
    end
    mem_resp = 1'b0; mem_rdata = 16'h0;
    #1;
    chk({tag, ".strobe_cycles"}, strobe_cycles, lat);
    chk({tag, ".resp_valid"}, {31'd0, resp_valid}, 32'd1);
    chk({tag, ".resp_rdata"}, {16'd0, resp_rdata}, {16'd0, exp_rdata});
    chk({tag, ".resp_tag"},   {29'd0, resp_tag},   {29'd0, rtag});
    chk_idle_outputs({tag, ".after"});
    tick;
    chk({tag, ".resp_pulse_end"}, {31'd0, resp_valid}, 32'd0);
  endtask

  logic [2:0] b2b_tags [3];

  initial begin
    rst_n = 1'b1; flush = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0;
    req_addr = '0; req_wdata = '0; req_tag = '0; mem_resp = 1'b0; mem_rdata = '0;
    b2b_tags[0] = 3'd6; b2b_tags[1] = 3'd7; b2b_tags[2] = 3'd0;
    #1 rst_n = 1'b0;
    #1;
    chk_idle_outputs("reset");
    chk("reset.resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("reset.resp_rdata", {16'd0, resp_rdata}, 32'd0);
    chk("reset.be", {30'd0, mem_byte_enable}, 32'd0);
    tick; tick;
    rst_n = 1'b1;
    tick;

    // 1: word load, 3-cycle cache
    do_access("ld_word", 1'b0, 1'b0, 16'h1004, 16'h0000, 3'd5, 3, 16'hBEEF,
              16'h1004, 16'h0000, 2'b11, 16'hBEEF);
    // 2: word store to an odd address is word-aligned
    do_access("st_word", 1'b1, 1'b0, 16'h2001, 16'h1234, 3'd2, 2, 16'h9999,
              16'h2000, 16'h1234, 2'b11, 16'h0000);

    // Flush in IDLE blocks acceptance
    req_valid = 1'b1; req_addr = 16'h0AAA; req_tag = 3'd1; flush = 1'b1;
    #1;
    chk("idle_flush.ready", {31'd0, req_ready}, 32'd0);
    tick;
    req_valid = 1'b0; flush = 1'b0;
    #1;
    chk("idle_flush.busy", {31'd0, busy}, 32'd0);

    // 3: flush in ACCESS -> DRAIN, strobes held, no response
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h4000; req_tag = 3'd1;
    tick;
    req_valid = 1'b0; flush = 1'b1;
    #1;
    chk("drain.ready_in_access", {31'd0, req_ready}, 32'd0);
    tick;
    flush = 1'b0;
    #1;
    chk("drain.rd", {31'd0, mem_read}, 32'd1);
    chk("drain.addr", {16'd0, mem_address}, 32'h4000);
    chk("drain.busy", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    #1;
    chk("drain.rd_held", {31'd0, mem_read}, 32'd1);
    chk("drain.addr_held", {16'd0, mem_address}, 32'h4000);
    mem_resp = 1'b1; mem_rdata = 16'h5555;
    tick;
    mem_resp = 1'b0;
    #1;
    chk("drain.no_resp", {31'd0, resp_valid}, 32'd0);
    chk_idle_outputs("drain.end");
    tick;
    chk("drain.no_resp_late", {31'd0, resp_valid}, 32'd0);

    // 4: flush coincident with mem_resp
    req_valid = 1'b1; req_addr = 16'h0010; req_tag = 3'd3;
    tick;
    req_valid = 1'b0; mem_resp = 1'b1; flush = 1'b1; mem_rdata = 16'h7777;
    tick;
    mem_resp = 1'b0; flush = 1'b0;
    #1;
    chk("flush_resp.no_resp", {31'd0, resp_valid}, 32'd0);
    chk_idle_outputs("flush_resp.idle");
    do_access("flush_resp.next", 1'b0, 1'b0, 16'h0012, 16'h0000, 3'd4, 1, 16'h0A0A,
              16'h0012, 16'h0000, 2'b11, 16'h0A0A);

    // 5: back-to-back with req_valid held and a 1-cycle cache
    req_valid = 1'b1; req_write = 1'b0; req_byte = 1'b0; req_addr = 16'h0100; req_tag = b2b_tags[0];
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("b2b.ready_accept", {31'd0, req_ready}, 32'd1);
      if (i > 0) begin
        chk("b2b.resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("b2b.resp_tag", {29'd0, resp_tag}, {29'd0, exp_q.pop_front()});
        chk("b2b.resp_rdata", {16'd0, resp_rdata}, 32'h1000 + i - 1);
      end
      exp_q.push_back(b2b_tags[i]);
      tick;
      mem_resp = 1'b1; mem_rdata = 16'h1000 + 16'(i);
      if (i < 2) req_tag = b2b_tags[i+1];
      else       req_valid = 1'b0;
      #1;
      chk("b2b.ready_busy", {30'd0, req_ready, busy}, 32'd1);
      chk("b2b.no_resp_in_access", {31'd0, resp_valid}, 32'd0);
      tick;
      mem_resp = 1'b0;
    end
    #1;
    chk("b2b.last_valid", {31'd0, resp_valid}, 32'd1);
    chk("b2b.last_tag", {29'd0, resp_tag}, {29'd0, exp_q.pop_front()});
    chk("b2b.queue_empty", exp_q.size(), 0);
    tick;

    // Reset in the middle of an access
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h5678; req_wdata = 16'hCAFE; req_tag = 3'd2;
    tick;
    req_valid = 1'b0;
    #1;
    chk("rst_mid.pre_write", {31'd0, mem_write}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("rst_mid");
    chk("rst_mid.wdata", {16'd0, mem_wdata}, 32'd0);
    chk("rst_mid.be", {30'd0, mem_byte_enable}, 32'd0);
    chk("rst_mid.resp_tag", {29'd0, resp_tag}, 32'd0);
    tick;
    rst_n = 1'b1;
    tick;

    // 6: byte accesses
`ifdef DMEM_BYTE_ACCESS_EN
    do_access("stb", 1'b1, 1'b1, 16'h3003, 16'h00AB, 3'd6, 1, 16'h0000,
              16'h3003, 16'hABAB, 2'b10, 16'h0000);
    do_access("ldb_hi", 1'b0, 1'b1, 16'h3003, 16'h0000, 3'd7, 2, 16'hC17F,
              16'h3003, 16'h0000, 2'b11, 16'h00C1);
    do_access("ldb_lo", 1'b0, 1'b1, 16'h3002, 16'h0000, 3'd1, 1, 16'hC17F,
              16'h3002, 16'h0000, 2'b11, 16'h007F);
    do_access("stb_lo", 1'b1, 1'b1, 16'h3002, 16'h1234, 3'd3, 1, 16'h0000,
              16'h3002, 16'h3434, 2'b01, 16'h0000);
`else
    do_access("ldb_off", 1'b0, 1'b1, 16'h3003, 16'h0000, 3'd7, 2, 16'hC17F,
              16'h3002, 16'h0000, 2'b11, 16'hC17F);
    do_access("stb_off", 1'b1, 1'b1, 16'h3003, 16'h00AB, 3'd6, 1, 16'h0000,
              16'h3002, 16'h00AB, 2'b11, 16'h0000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
